// File: rtl/cv32e40p_obi_credit_adapter.sv
// Credit-limited OBI master adapter: holds the A channel stable across grant stalls and buffers R responses in order.
// A channel is combinational from trans_* until a stall, then registered; responses appear one cycle after obi_rvalid_i.
module cv32e40p_obi_credit_adapter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    trans_valid_i,
    output logic                    trans_ready_o,
    input  logic [ADDR_WIDTH-1:0]   trans_addr_i,
    input  logic                    trans_we_i,
    input  logic [DATA_WIDTH-1:0]   trans_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] trans_be_i,
    input  logic [5:0]              trans_atop_i,

    output logic                    resp_valid_o,
    output logic [DATA_WIDTH-1:0]   resp_rdata_o,
    output logic                    resp_err_o,
    input  logic                    resp_ready_i,

    output logic                    obi_req_o,
    input  logic                    obi_gnt_i,
    output logic [ADDR_WIDTH-1:0]   obi_addr_o,
    output logic                    obi_we_o,
    output logic [DATA_WIDTH-1:0]   obi_wdata_o,
    output logic [DATA_WIDTH/8-1:0] obi_be_o,
    output logic [5:0]              obi_atop_o,

    input  logic                    obi_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   obi_rdata_i,
    input  logic                    obi_err_i,

    output logic [CW-1:0]           outstanding_o,
    output logic                    protocol_err_o
);
    localparam int BW = DATA_WIDTH / 8;
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);

    typedef enum logic {TRANSPARENT, REGISTERED} state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [CW-1:0]           occ_q, occ_d;
    logic [PW-1:0]           wptr_q, wptr_d;
    logic [PW-1:0]           rptr_q, rptr_d;
    logic [DATA_WIDTH:0]     mem_q [MAX_OUTSTANDING];
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    we_q, we_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [BW-1:0]           be_q, be_d;
    logic [5:0]              atop_q, atop_d;
    logic                    perr_q, perr_d;

    logic                    credit_ok;
    logic                    grant;
    logic                    push;
    logic                    pop;
    logic [CW-1:0]           in_flight;
    logic [DATA_WIDTH:0]     head;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign credit_ok = (cnt_q < MAX_CNT);

    // Once stalled, the request is never retracted and must not track trans_* any more.
    always_comb begin
        obi_req_o     = 1'b0;
        trans_ready_o = 1'b0;
        if (!rst) begin
            if (state_q == REGISTERED) begin
                obi_req_o = 1'b1;
            end else begin
                obi_req_o     = trans_valid_i && credit_ok;
                trans_ready_o = credit_ok;
            end
        end
        if (state_q == REGISTERED) begin
            obi_addr_o  = addr_q;
            obi_we_o    = we_q;
            obi_wdata_o = wdata_q;
            obi_be_o    = be_q;
            obi_atop_o  = atop_q;
        end else begin
            obi_addr_o  = trans_addr_i;
            obi_we_o    = trans_we_i;
            obi_wdata_o = trans_wdata_i;
            obi_be_o    = trans_be_i;
            obi_atop_o  = trans_atop_i;
        end
    end

    assign grant          = obi_req_o && obi_gnt_i;
    assign resp_valid_o   = !rst && (occ_q != '0);
    assign pop            = resp_valid_o && resp_ready_i;
    assign in_flight      = cnt_q - occ_q;
    assign push           = obi_rvalid_i && (in_flight != '0);
    assign head           = mem_q[rptr_q];
    assign resp_rdata_o   = resp_valid_o ? head[DATA_WIDTH:1] : '0;
    assign resp_err_o     = resp_valid_o ? head[0] : 1'b0;
    assign outstanding_o  = rst ? '0 : cnt_q;
    assign protocol_err_o = !rst && perr_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        atop_d  = atop_q;
        case (state_q)
            TRANSPARENT: begin
                if (obi_req_o && !obi_gnt_i) begin
                    state_d = REGISTERED;
                    addr_d  = trans_addr_i;
                    we_d    = trans_we_i;
                    wdata_d = trans_wdata_i;
                    be_d    = trans_be_i;
                    atop_d  = trans_atop_i;
                end
            end
            default: begin
                if (obi_gnt_i) state_d = TRANSPARENT;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({grant, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: occ_d = occ_q;
        endcase
        wptr_d = push ? ptr_next(wptr_q) : wptr_q;
        rptr_d = pop  ? ptr_next(rptr_q) : rptr_q;
        perr_d = obi_rvalid_i && (in_flight == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TRANSPARENT;
            cnt_q   <= '0;
            occ_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
            atop_q  <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            occ_q   <= occ_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            atop_q  <= atop_d;
            perr_q  <= perr_d;
        end
    end

    // Storage needs no reset: the read side is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!rst && push) mem_q[wptr_q] <= {obi_rdata_i, obi_err_i};
    end
endmodule

// File: tb/tb_cv32e40p_obi_credit_adapter.sv
// Directed and randomized bench with a queue-based transaction model of the credit adapter.
module tb_cv32e40p_obi_credit_adapter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MAXO = 2;
    localparam int CW = $clog2(MAXO + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            trans_valid_i, trans_ready_o;
    logic [AW-1:0]   trans_addr_i;
    logic            trans_we_i;
    logic [DW-1:0]   trans_wdata_i;
    logic [DW/8-1:0] trans_be_i;
    logic [5:0]      trans_atop_i;
    logic            resp_valid_o;
    logic [DW-1:0]   resp_rdata_o;
    logic            resp_err_o, resp_ready_i;
    logic            obi_req_o, obi_gnt_i;
    logic [AW-1:0]   obi_addr_o;
    logic            obi_we_o;
    logic [DW-1:0]   obi_wdata_o;
    logic [DW/8-1:0] obi_be_o;
    logic [5:0]      obi_atop_o;
    logic            obi_rvalid_i;
    logic [DW-1:0]   obi_rdata_i;
    logic            obi_err_i;
    logic [CW-1:0]   outstanding_o;
    logic            protocol_err_o;

    int checks = 0;
    int failures = 0;

    // Reference model: credits, buffered responses, and the stalled request if any.
    int              m_cnt;
    logic [DW:0]     m_q[$];
    bit              m_pend;
    bit              m_perr;
    logic [AW-1:0]   c_addr;
    logic            c_we;
    logic [DW-1:0]   c_wdata;
    logic [DW/8-1:0] c_be;
    logic [5:0]      c_atop;

    cv32e40p_obi_credit_adapter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst(rst),
        .trans_valid_i(trans_valid_i), .trans_ready_o(trans_ready_o),
        .trans_addr_i(trans_addr_i), .trans_we_i(trans_we_i),
        .trans_wdata_i(trans_wdata_i), .trans_be_i(trans_be_i),
        .trans_atop_i(trans_atop_i),
        .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
        .resp_err_o(resp_err_o), .resp_ready_i(resp_ready_i),
        .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o),
        .obi_we_o(obi_we_o), .obi_wdata_o(obi_wdata_o), .obi_be_o(obi_be_o),
        .obi_atop_o(obi_atop_o),
        .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i), .obi_err_i(obi_err_i),
        .outstanding_o(outstanding_o), .protocol_err_o(protocol_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [AW-1:0] a, input bit g,
                         input bit rv, input logic [DW-1:0] rd, input bit rr);
        trans_valid_i = v;
        trans_addr_i  = a;
        trans_we_i    = 1'($urandom);
        trans_wdata_i = $urandom;
        trans_be_i    = 4'($urandom);
        trans_atop_i  = 6'($urandom);
        obi_gnt_i     = g;
        obi_rvalid_i  = rv;
        obi_rdata_i   = rd;
        obi_err_i     = 1'b0;
        resp_ready_i  = rr;
    endtask

    // One clock: compare outputs mid-cycle, advance the model, return just after the edge.
    task automatic cycle();
        logic e_req, e_rdy, e_rv, e_err, e_perr;
        logic [DW-1:0] e_rd;
        int e_out, infl;
        @(negedge clk);
        if (rst) begin
            e_req = 0; e_rdy = 0; e_rv = 0; e_rd = '0; e_err = 0; e_out = 0; e_perr = 0;
        end else begin
            e_rdy  = !m_pend && (m_cnt < MAXO);
            e_req  = m_pend || (trans_valid_i && (m_cnt < MAXO));
            e_rv   = (m_q.size() > 0);
            e_rd   = e_rv ? m_q[0][DW:1] : '0;
            e_err  = e_rv ? m_q[0][0] : 1'b0;
            e_out  = m_cnt;
            e_perr = m_perr;
        end
        chk("trans_ready", trans_ready_o, e_rdy);
        chk("obi_req", obi_req_o, e_req);
        chk("resp_valid", resp_valid_o, e_rv);
        chk("resp_rdata", resp_rdata_o, e_rd);
        chk("resp_err", resp_err_o, e_err);
        chk("outstanding", outstanding_o, e_out);
        chk("protocol_err", protocol_err_o, e_perr);
        if (e_req) begin
            chk("obi_addr",  obi_addr_o,  m_pend ? c_addr  : trans_addr_i);
            chk("obi_we",    obi_we_o,    m_pend ? c_we    : trans_we_i);
            chk("obi_wdata", obi_wdata_o, m_pend ? c_wdata : trans_wdata_i);
            chk("obi_be",    obi_be_o,    m_pend ? c_be    : trans_be_i);
            chk("obi_atop",  obi_atop_o,  m_pend ? c_atop  : trans_atop_i);
        end
        if (rst) begin
            m_cnt = 0; m_q.delete(); m_pend = 0; m_perr = 0;
        end else begin
            infl   = m_cnt - m_q.size();
            m_perr = obi_rvalid_i && (infl == 0);
            if (e_rv && resp_ready_i) begin
                void'(m_q.pop_front());
                m_cnt--;
            end
            if (obi_rvalid_i && infl > 0) m_q.push_back({obi_rdata_i, obi_err_i});
            if (e_req && obi_gnt_i) begin
                m_cnt++;
                m_pend = 0;
            end else if (e_req && !m_pend) begin
                m_pend = 1; c_addr = trans_addr_i; c_we = trans_we_i;
                c_wdata = trans_wdata_i; c_be = trans_be_i; c_atop = trans_atop_i;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int infl;
        m_cnt = 0; m_pend = 0; m_perr = 0;
        rst = 1'b1;
        drive(0, '0, 0, 0, '0, 0);
        @(posedge clk);
        #1;
        cycle();
        cycle();
        rst = 1'b0;

        // Single read, rvalid two cycles after the grant.
        drive(1, 32'h10, 1, 0, '0, 0);
        #1 chk("single_out_grant", outstanding_o, 0);
        cycle();
        drive(0, '0, 0, 0, '0, 0);
        chk("single_out_after", outstanding_o, 1);
        cycle();
        drive(0, '0, 0, 1, 32'hDEADBEEF, 0);
        cycle();
        drive(0, '0, 0, 0, '0, 1);
        chk("single_rdata", resp_rdata_o, 32'hDEADBEEF);
        cycle();
        drive(0, '0, 0, 0, '0, 0);
        chk("single_out_end", outstanding_o, 0);
        cycle();

        // Grant stall while the request payload changes underneath.
        drive(1, 32'h100, 0, 0, '0, 1);
        cycle();
        for (int i = 0; i < 2; i++) begin
            drive(1, 32'h200, 0, 0, '0, 1);
            #1 chk("stall_addr", obi_addr_o, 32'h100);
            chk("stall_ready", trans_ready_o, 0);
            cycle();
        end
        drive(1, 32'h200, 1, 0, '0, 1);
        #1 chk("stall_gnt_addr", obi_addr_o, 32'h100);
        cycle();
        drive(0, '0, 0, 1, 32'h1234, 1);
        cycle();
        drive(0, '0, 0, 0, '0, 1);
        cycle();

        // Credit exhaustion, then full-FIFO pop alongside a new response.
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h300 + 32'(i), 1, 0, '0, 0);
            cycle();
        end
        chk("credit_limit_req", obi_req_o, 0);
        drive(1, 32'h400, 1, 1, 32'hA1, 0);
        cycle();
        drive(1, 32'h400, 1, 1, 32'hA2, 0);
        cycle();
        drive(1, 32'h400, 1, 0, '0, 1);
        chk("full_no_req", obi_req_o, 0);
        cycle();
        drive(1, 32'h404, 1, 0, '0, 0);
        chk("freed_credit_req", obi_req_o, 1);
        cycle();
        drive(0, '0, 0, 1, 32'hA3, 1);
        cycle();
        for (int i = 0; i < 3; i++) begin
            drive(0, '0, 0, 0, '0, 1);
            cycle();
        end

        // Unexpected response with nothing outstanding.
        drive(0, '0, 0, 1, 32'hBAD, 1);
        cycle();
        drive(0, '0, 0, 0, '0, 1);
        chk("perr_pulse", protocol_err_o, 1);
        cycle();
        chk("perr_clear", protocol_err_o, 0);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            infl = m_cnt - m_q.size();
            drive($urandom_range(0, 9) < 6, $urandom, 1'($urandom),
                  (infl > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 29) == 0),
                  $urandom, $urandom_range(0, 9) < 6);
            obi_err_i = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 249) == 0);
            cycle();
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(0, '0, 0, m_cnt > m_q.size(), $urandom, 1);
            cycle();
        end

        // Reset with one response buffered and one in flight; the late rvalid is dropped.
        drive(1, 32'h500, 1, 0, '0, 0);
        cycle();
        drive(1, 32'h504, 1, 0, '0, 0);
        cycle();
        drive(0, '0, 0, 1, 32'hC0, 0);
        cycle();
        rst = 1'b1;
        drive(0, '0, 0, 0, '0, 0);
        cycle();
        rst = 1'b0;
        chk("rst_resp_valid", resp_valid_o, 0);
        chk("rst_outstanding", outstanding_o, 0);
        drive(0, '0, 0, 1, 32'hC1, 1);
        cycle();
        drive(0, '0, 0, 0, '0, 1);
        chk("late_rvalid_flag", protocol_err_o, 1);
        chk("late_rvalid_drop", resp_valid_o, 0);
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
